// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared constants and state encoding for the RV32I fetch stage
package if_fetch_pkg;
  localparam int          XLEN_WIDTH       = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam logic        TRUE             = 1'b1;
  localparam logic        FALSE            = 1'b0;
  typedef enum logic [1:0] {BOOT, FETCH, DRAIN} state_t;
endpackage

// File: rtl/if_fetch_fifo.sv
// if_fifo: prefetch FIFO holding {instruction, pc} pairs with push/pop/flush/count
module if_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [AW:0]   count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr, rd;
  // storage needs no reset; entry validity is carried by count
  always_ff @(posedge clk)
    if (push) mem[wr] <= din;
  // pointers and occupancy; flush drops every entry at once
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr    <= '0;
      rd    <= '0;
      count <= '0;
    end else if (flush) begin
      wr    <= '0;
      rd    <= '0;
      count <= '0;
    end else begin
      wr    <= push ? wr + AW'(1) : wr;
      rd    <= pop ? rd + AW'(1) : rd;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  assign head = mem[rd];
endmodule

// File: rtl/if_fetch.sv
// if_fetch: RV32I fetch stage with credit-limited prefetch and redirect flush; IF_FETCH_BYPASS_EN adds same-cycle response bypass
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int              XLEN       = XLEN_WIDTH,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEFAULT),
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_addr,
  output logic            inst_valid,
  input  logic            pause,
  input  logic            jump_en,
  input  logic [XLEN-1:0] jump_addr
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t            state;
  logic [XLEN-1:0]   fetch_pc, resp_pc, head_inst, head_addr, target;
  logic [2*XLEN-1:0] head;
  logic [CW-1:0]     outstanding, discard, fifo_count, out_next, disc_next;
  logic [CW:0]       credit;
  logic              issue, rv, keep, byp, push, pop, fifo_valid;
  assign target     = jump_addr & ~XLEN'(3);
  assign credit     = {1'b0, fifo_count} + {1'b0, outstanding};
  assign imem_req   = state != BOOT && !jump_en && credit < (CW+1)'(FIFO_DEPTH);
  assign imem_addr  = fetch_pc;
  assign issue      = imem_req && imem_gnt;
  assign rv         = imem_rvalid && outstanding != '0;
  assign keep       = rv && discard == '0 && !jump_en;
`ifdef IF_FETCH_BYPASS_EN
  assign byp        = keep && fifo_count == '0 && !pause;
`else
  assign byp        = FALSE;
`endif
  assign push       = keep && !byp;
  assign fifo_valid = fifo_count != '0;
  assign pop        = fifo_valid && !pause && !jump_en;
  assign out_next   = outstanding + CW'(issue) - CW'(rv);
  assign disc_next  = jump_en ? out_next : discard - CW'(rv && discard != '0);
  assign head_inst  = head[2*XLEN-1:XLEN];
  assign head_addr  = head[XLEN-1:0];
  assign inst_valid = byp ? TRUE : fifo_valid;
  assign inst       = byp ? imem_rdata : fifo_valid ? head_inst : XLEN'(NOP);
  assign inst_addr  = byp ? resp_pc : fifo_valid ? head_addr : '0;
  if_fifo #(.W(2*XLEN), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (jump_en),
    .din   ({imem_rdata, resp_pc}),
    .head  (head),
    .count (fifo_count)
  );
  // state, request/response PCs and in-flight bookkeeping; a redirect turns all in-flight requests into discards
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= BOOT;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      state       <= state == BOOT ? FETCH : disc_next != '0 ? DRAIN : FETCH;
      fetch_pc    <= jump_en ? target : issue ? fetch_pc + XLEN'(4) : fetch_pc;
      resp_pc     <= jump_en ? target : keep ? resp_pc + XLEN'(4) : resp_pc;
      outstanding <= out_next;
      discard     <= disc_next;
    end
`ifndef SYNTHESIS
  // a response with nothing in flight breaks the memory protocol
  always_ff @(posedge clk)
    if (rst_n && imem_rvalid) assert (outstanding != '0);
`endif
endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- RV32I instruction-fetch stage, directly upstream of the decode stage.
- Issues word fetches to instruction memory over a req/gnt/rvalid handshake and holds returned words plus their PCs in a small prefetch FIFO.
- Presents one instruction and its address per cycle to decode.
- Honours decode `pause` (hold output) and execute-stage `jump_en`/`jump_addr` redirects; stale in-flight responses are flushed.

Parameters:
- XLEN, 32, datapath/address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 4, prefetch entries; power of two, at least 2; also the outstanding-request limit.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- imem_req  out  1  fetch request valid
- imem_addr  out  XLEN  fetch word address, bits [1:0] always 0
- imem_gnt  in  1  memory accepted request this cycle
- imem_rvalid  in  1  read data valid, in-order, latency ≥1 cycle after gnt
- imem_rdata  in  XLEN  read data
- inst  out  XLEN  instruction to decode; 32'h0000_0013 (NOP) when inst_valid=0
- inst_addr  out  XLEN  PC of inst; 0 when inst_valid=0
- inst_valid  out  1  inst/inst_addr meaningful
- pause  in  1  decode stall: hold current head, no pop
- jump_en  in  1  redirect request
- jump_addr  in  XLEN  redirect target; bits [1:0] ignored (forced 0)

Behaviour:
- Reset:
  - Asynchronous, active-low: applies immediately on rst_n=0, independent of clk.
  - fetch_pc=RESET_PC, FIFO empty, outstanding=0, discard=0.
  - imem_req=0, inst_valid=0, inst=NOP, inst_addr=0.
  - State=BOOT.
  - Reset asserted mid-transaction: every counter cleared. Responses that arrive after reset release are not tracked; the memory is reset together with this block.
- State machine:
  - BOOT: one cycle, imem_req=0, then FETCH.
  - FETCH: normal operation.
  - DRAIN: entered on jump_en when stale requests remain in flight. Returns to FETCH in the cycle discard reaches 0.
  - imem_req may assert in DRAIN (new-target requests queue behind the stale ones).
- Issue:
  - imem_req=1 when state≠BOOT, jump_en=0, and fifo_count + outstanding < FIFO_DEPTH.
  - imem_addr=fetch_pc.
  - On imem_req&&imem_gnt: fetch_pc += 4 (wraps modulo 2^XLEN), outstanding++.
  - req may drop while ungranted only because of jump_en or the credit rule. Memory must tolerate withdrawal.
- Response:
  - On imem_rvalid: outstanding--.
  - If discard>0: discard-- and the data is dropped.
  - Otherwise push {imem_rdata, pc_of_response}. Response PCs come from an internal in-order PC queue, or equivalently a resp_pc counter.
  - The credit rule guarantees the FIFO never overflows. An rvalid with outstanding=0 is a protocol violation: ignored, with a simulation assertion.
- Output:
  - Head of FIFO is registered.
  - inst_valid = (fifo_count>0).
  - Pop when inst_valid && !pause && !jump_en.
  - Push and pop in the same cycle are both applied; count is unchanged.
- Redirect (jump_en=1):
  - FIFO cleared, inst_valid=0 next cycle.
  - fetch_pc=jump_addr&~3; resp_pc=the same value.
  - discard = outstanding after the current cycle's gnt/rvalid updates, excluding any rvalid already consumed this cycle. Any rvalid arriving in the jump cycle is itself dropped.
  - Next state: DRAIN if discard>0, else FETCH.
  - No imem_req in the jump cycle.
  - jump_en wins over pause and over pop.
  - Back-to-back jumps: the latest target wins and discard is recomputed.
- Latency:
  - Reset release to first imem_req: 2 cycles.
  - rvalid to inst_valid: 1 cycle.
  - jump_en to first new imem_req: 1 cycle.

Optional Feature:
- Macro: IF_FETCH_BYPASS_EN.
- Defined: when the FIFO is empty, discard=0, pause=0, jump_en=0 and imem_rvalid=1, the response drives inst/inst_addr/inst_valid combinationally in the same cycle and is not pushed. Response-to-decode latency becomes 0 cycles.
- Undefined: all output comes from the FIFO, so outputs are purely registered.

Decomposition:
- Shared package/define file:
  - NOP encoding 32'h0000_0013.
  - XLEN_WIDTH, RESET_PC default.
  - true/false constants (already in const.v).
- One sub-module: if_fifo, a synchronous FIFO of width 2×XLEN and depth FIFO_DEPTH with push/pop/flush/count.
- FSM, credit, PC and discard logic stay in if_fetch.

Test Plan:
- Reset, zero-wait memory (gnt=1, rvalid 1 cycle later, rdata=addr^32'hA5A5_0000) → inst_addr sequence 0,4,8,C on consecutive cycles after first valid; inst matches.
- pause=1 for 5 cycles with FIFO full (4 entries) → inst/inst_addr stable, imem_req=0 while fifo_count+outstanding=4; resumes in order after release.
- Memory latency 3 cycles, jump_en with jump_addr=32'h0000_0103 while 2 requests are outstanding → next imem_addr=32'h100, both stale responses dropped, first inst_addr=32'h100.
- jump_en and pause together with FIFO non-empty → FIFO flushed, inst_valid=0 next cycle, fetch restarts at target.
- fetch_pc=32'hFFFF_FFFC → next issued address 32'h0000_0000 (wrap).
- rst_n pulsed low mid-burst (asynchronous, not on clock edge) → outputs immediately at reset values; after release first imem_addr=RESET_PC. With IF_FETCH_BYPASS_EN, an empty-FIFO response shows inst_valid in the rvalid cycle.
